// File: rtl/dcs_load_sched.sv
// Job sequencer for the DCSformer core: streams weights (with backpressure),
// then inputs, then counts result strobes before pulsing done.
module dcs_load_sched #(
  parameter int W_LEN = 64,
  parameter int I_LEN = 64,
  parameter int O_LEN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        err,
  input  logic        ws_valid,
  input  logic [7:0]  ws_data,
  output logic        ws_ready,
  input  logic        is_valid,
  input  logic [7:0]  is_data,
  output logic        is_ready,
  output logic        w_valid,
  output logic [7:0]  w_data,
  input  logic        w_ready,
  output logic        i_valid,
  output logic [7:0]  i_data,
  input  logic        o_valid,
  output logic [15:0] o_cnt
);

  localparam int WW = $clog2(W_LEN + 1);
  localparam int IW = $clog2(I_LEN + 1);
  localparam int OW = $clog2(O_LEN + 1);
  localparam logic [WW-1:0] W_MAX = WW'(W_LEN);
  localparam logic [IW-1:0] I_MAX = IW'(I_LEN);
  localparam logic [OW-1:0] O_MAX = OW'(O_LEN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_W = 3'd1,
    S_LOAD_I = 3'd2,
    S_WAIT_O = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wcnt_in_q, wcnt_in_d, wcnt_out_q, wcnt_out_d;
  logic [IW-1:0] icnt_q, icnt_d;
  logic [OW-1:0] ocnt_q, ocnt_d;
  logic          err_q, err_d, busy_q, busy_d, done_q, done_d;
  logic          w_valid_q, w_valid_d, i_valid_q, i_valid_d;
  logic [7:0]    w_data_q, w_data_d, i_data_q, i_data_d;
  logic          w_load, w_drain;

  // Next-state, counters, one-entry weight register and handshake readies.
  always_comb begin
    state_d    = state_q;
    wcnt_in_d  = wcnt_in_q;
    wcnt_out_d = wcnt_out_q;
    icnt_d     = icnt_q;
    ocnt_d     = ocnt_q;
    err_d      = err_q;
    w_valid_d  = w_valid_q;
    w_data_d   = w_data_q;
    i_valid_d  = 1'b0;
    i_data_d   = i_data_q;
    ws_ready   = 1'b0;
    is_ready   = 1'b0;
    w_load     = 1'b0;
    w_drain    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD_W;
          wcnt_in_d  = '0;
          wcnt_out_d = '0;
          icnt_d     = '0;
          ocnt_d     = '0;
          err_d      = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_W: begin
        ws_ready = (wcnt_in_q < W_MAX) && (!w_valid_q || w_ready);
        w_load   = ws_valid && ws_ready;
        w_drain  = w_valid_q && w_ready;
        // A load wins over a drain so the register refills without a bubble.
        if (w_load) begin
          w_valid_d = 1'b1;
          w_data_d  = ws_data;
          wcnt_in_d = wcnt_in_q + WW'(1);
        end else if (w_drain) begin
          w_valid_d = 1'b0;
        end else begin
          w_valid_d = w_valid_q;
        end
        if (w_drain) begin
          wcnt_out_d = wcnt_out_q + WW'(1);
          if (wcnt_out_q == W_MAX - WW'(1)) begin
            state_d = S_LOAD_I;
          end else begin
            state_d = S_LOAD_W;
          end
        end else begin
          wcnt_out_d = wcnt_out_q;
        end
      end
      S_LOAD_I: begin
        is_ready = (icnt_q < I_MAX);
        if (is_valid && is_ready) begin
          i_valid_d = 1'b1;
          i_data_d  = is_data;
          icnt_d    = icnt_q + IW'(1);
          if (icnt_q == I_MAX - IW'(1)) begin
            state_d = S_WAIT_O;
          end else begin
            state_d = S_LOAD_I;
          end
        end else begin
          i_valid_d = 1'b0;
        end
      end
      S_WAIT_O: begin
        if (o_valid) begin
          ocnt_d = ocnt_q + OW'(1);
          if (ocnt_q == O_MAX - OW'(1)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_O;
          end
        end else begin
          ocnt_d = ocnt_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A result strobe outside the result window is flagged, never counted.
    if (o_valid && (state_q != S_WAIT_O)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_d;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_in_q  <= '0;
      wcnt_out_q <= '0;
      icnt_q     <= '0;
      ocnt_q     <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      w_valid_q  <= 1'b0;
      w_data_q   <= 8'h00;
      i_valid_q  <= 1'b0;
      i_data_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      wcnt_in_q  <= wcnt_in_d;
      wcnt_out_q <= wcnt_out_d;
      icnt_q     <= icnt_d;
      ocnt_q     <= ocnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      w_valid_q  <= w_valid_d;
      w_data_q   <= w_data_d;
      i_valid_q  <= i_valid_d;
      i_data_q   <= i_data_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign w_valid = w_valid_q;
  assign w_data  = w_data_q;
  assign i_valid = i_valid_q;
  assign i_data  = i_data_q;
  assign o_cnt   = 16'(ocnt_q);

endmodule

// File: tb/tb_dcs_load_sched.sv
// Randomized bench for dcs_load_sched against a job-level reference model
// (byte queue for the weight register, plain counters for progress).
module tb_dcs_load_sched;

  localparam int WL = 4;
  localparam int IL = 3;
  localparam int OL = 2;
  localparam int NOMINAL_LEN = 1 + (WL + 1) + IL + OL + 1;

  logic        clk = 1'b0;
  logic        rst, start, ws_valid, is_valid, w_ready, o_valid;
  logic [7:0]  ws_data, is_data;
  logic        busy, done, err, ws_ready, is_ready, w_valid, i_valid;
  logic [7:0]  w_data, i_data;
  logic [15:0] o_cnt;

  always #5 clk = ~clk;

  dcs_load_sched #(.W_LEN(WL), .I_LEN(IL), .O_LEN(OL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .ws_valid(ws_valid), .ws_data(ws_data), .ws_ready(ws_ready),
    .is_valid(is_valid), .is_data(is_data), .is_ready(is_ready),
    .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .i_valid(i_valid), .i_data(i_data), .o_valid(o_valid), .o_cnt(o_cnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 weights, 2 inputs, 3 results, 4 finishing.
  int         ph, ws_in, ws_out, i_in, o_n;
  logic       m_err, m_iv;
  logic [7:0] m_wd, m_id;
  logic [7:0] wq[$];
  int         cyc, start_cyc, dut_wx, dut_ix;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    ph = 0; ws_in = 0; ws_out = 0; i_in = 0; o_n = 0;
    m_err = 1'b0; m_iv = 1'b0; m_wd = 8'h00; m_id = 8'h00;
    wq.delete();
    dut_wx = 0; dut_ix = 0;
  endfunction

  function automatic logic exp_ws_ready();
    return (ph == 1) && (ws_in < WL) && ((wq.size() == 0) || w_ready);
  endfunction

  task automatic check_outputs(input bit nominal);
    check_eq("busy",     32'(busy),     32'(ph != 0));
    check_eq("done",     32'(done),     32'(ph == 4));
    check_eq("err",      32'(err),      32'(m_err));
    check_eq("ws_ready", 32'(ws_ready), 32'(exp_ws_ready()));
    check_eq("is_ready", 32'(is_ready), 32'((ph == 2) && (i_in < IL)));
    check_eq("w_valid",  32'(w_valid),  32'(wq.size() != 0));
    check_eq("w_data",   32'(w_data),   32'(m_wd));
    check_eq("i_valid",  32'(i_valid),  32'(m_iv));
    check_eq("i_data",   32'(i_data),   32'(m_id));
    check_eq("o_cnt",    32'(o_cnt),    32'(o_n));
    if (w_valid && w_ready) dut_wx++;
    if (i_valid) dut_ix++;
    if (done) begin
      check_eq("w_xfers", 32'(dut_wx), 32'(WL));
      check_eq("i_pulses", 32'(dut_ix), 32'(IL));
      if (nominal) check_eq("job_len", 32'(cyc - start_cyc + 1), 32'(NOMINAL_LEN));
    end
  endtask

  task automatic model_step();
    int ph0;
    logic wsr;
    ph0 = ph;
    wsr = exp_ws_ready();
    m_iv = 1'b0;
    if (rst) begin
      model_reset();
    end else begin
      case (ph)
        0: if (start) begin
             ph = 1; ws_in = 0; ws_out = 0; i_in = 0; o_n = 0; m_err = 1'b0;
             dut_wx = 0; dut_ix = 0; start_cyc = cyc;
           end
        1: begin
             if ((wq.size() != 0) && w_ready) begin
               void'(wq.pop_front());
               ws_out++;
             end
             if (ws_valid && wsr) begin
               wq.push_back(ws_data);
               m_wd = ws_data;
               ws_in++;
             end
             if (ws_out == WL) ph = 2;
           end
        2: if (is_valid && (i_in < IL)) begin
             m_iv = 1'b1;
             m_id = is_data;
             i_in++;
             if (i_in == IL) ph = 3;
           end
        3: if (o_valid) begin
             o_n++;
             if (o_n == OL) ph = 4;
           end
        default: ph = 0;
      endcase
      if (o_valid && (ph0 != 3)) m_err = 1'b1;
    end
  endtask

  task automatic run_phase(input int n, input int p_start, input int p_wv, input int p_wr,
                           input int p_iv, input int p_ov, input int p_spur, input int p_rst,
                           input bit nominal);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start    = ($urandom_range(99) < p_start);
      ws_valid = ($urandom_range(99) < p_wv);
      ws_data  = 8'($urandom());
      w_ready  = ($urandom_range(99) < p_wr);
      is_valid = ($urandom_range(99) < p_iv);
      is_data  = 8'($urandom());
      o_valid  = (ph == 3) ? ($urandom_range(99) < p_ov) : ($urandom_range(99) < p_spur);
      rst      = (k < 2) || ((ph == 2) && (i_in == 1) && ($urandom_range(99) < p_rst));
      #1;
      check_outputs(nominal);
      model_step();
      cyc++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ws_valid = 1'b0; ws_data = 8'h00; w_ready = 1'b0;
    is_valid = 1'b0; is_data = 8'h00; o_valid = 1'b0;
    cyc = 0; start_cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    // Stall-free back-to-back jobs; checks the minimum job length.
    run_phase(80, 100, 100, 100, 100, 100, 0, 0, 1'b1);
    // Random backpressure, input gaps, spurious results, mid-job resets.
    run_phase(1500, 25, 70, 50, 60, 50, 2, 30, 1'b0);
    // Heavy weight stalls and sparse inputs, constant start pulses.
    run_phase(1000, 80, 90, 20, 30, 40, 0, 0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcs_load_sched.md
# dcs_load_sched

Job sequencer in front of the DCSformer datapath. Per job it streams W_LEN weight bytes from a weight source into the datapath's weight port, honouring `w_ready`. It then streams I_LEN input bytes into the input port and counts O_LEN `o_valid` results before signalling completion. It sits between the host-side byte sources and the DCSformer core, and is the only driver of the core's `w_valid/w_data/i_valid/i_data`.

## Interface
- `W_LEN`, 64: weight bytes per job (≥1)
- `I_LEN`, 64: input bytes per job (≥1)
- `O_LEN`, 16: `o_valid` pulses expected per job (≥1)
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a job; sampled only in IDLE
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at job end
- `err`  out  1  sticky: `o_valid` seen outside WAIT_O; cleared by accepted `start` or `rst`
- `ws_valid`  in  1  weight source valid
- `ws_data`  in  8  weight source byte
- `ws_ready`  out  1  weight source ready
- `is_valid`  in  1  input source valid
- `is_data`  in  8  input source byte
- `is_ready`  out  1  input source ready
- `w_valid`  out  1  to core, registered
- `w_data`  out  8  to core, registered
- `w_ready`  in  1  from core
- `i_valid`  out  1  to core, registered
- `i_data`  out  8  to core, registered
- `o_valid`  in  1  from core, result strobe
- `o_cnt`  out  16  results counted in current/last job

## Operation
- FSM states: IDLE → LOAD_W → LOAD_I → WAIT_O → DONE → IDLE.
- IDLE:
  - `start` moves to LOAD_W.
  - Clears `wcnt_in`, `wcnt_out`, `icnt`, `o_cnt` and `err`.
- LOAD_W: one-entry output register (`w_valid/w_data`).
  - `ws_ready = (wcnt_in < W_LEN) && (!w_valid || w_ready)`.
  - A source transfer (`ws_valid && ws_ready`) loads the register, sets `w_valid`, and increments `wcnt_in`.
  - A core transfer (`w_valid && w_ready`) without a new load clears `w_valid`. Each core transfer increments `wcnt_out`.
  - Load and drain in the same cycle: the register takes the new byte and `w_valid` stays 1.
  - The core transfer that makes `wcnt_out == W_LEN` moves to LOAD_I.
  - `w_data` holds its value while `w_valid && !w_ready`.
- LOAD_I: the core has no ready on the input port.
  - `is_ready = (icnt < I_LEN)`.
  - Each source transfer registers `i_data <= is_data` and `i_valid <= 1`, and increments `icnt`. Otherwise `i_valid <= 0`.
  - Gaps on `is_valid` produce gaps on `i_valid`; the core tolerates them.
  - When the last byte is accepted (`icnt` becomes I_LEN), the next state is WAIT_O.
- WAIT_O:
  - Each `o_valid` increments `o_cnt`.
  - The pulse that makes `o_cnt == O_LEN` moves to DONE.
- DONE: `done = 1` for exactly this cycle, then IDLE. `o_cnt` holds until the next accepted `start`.
- `o_valid` in any state other than WAIT_O sets `err`. It is not counted and does not change state.
- `start` while `busy` is ignored.
- `ws_ready` is 0 outside LOAD_W; `is_ready` is 0 outside LOAD_I.
- Counters are sized `$clog2(N+1)`. They never exceed their limit and never wrap. `o_cnt` is zero-extended to 16 bits.

## Timing
- Reset values: `busy`, `done`, `err`, `ws_ready`, `is_ready`, `w_valid`, `i_valid` = 0; `w_data`, `i_data`, `o_cnt` = 0; state = IDLE.
- `rst` mid-job returns to IDLE the next edge. Any in-flight `w_valid`/`i_valid` drops and counters clear; no `done` is issued.
- `start` at edge t puts the FSM in LOAD_W at t+1. `ws_ready` can be 1 in that cycle.
- Source-to-core latency: 1 cycle for both ports. The weight path sustains 1 byte/cycle when `w_ready` is held high.
- Minimum job length with no stalls and back-to-back `o_valid`: 1 + (W_LEN+1) + I_LEN + O_LEN + 1 cycles.
- The last `i_valid` pulse occurs in the first WAIT_O cycle.
- `o_valid` in that same first WAIT_O cycle is counted.

## Test plan
- Nominal job, W_LEN=4, I_LEN=3, O_LEN=2:
  - Stimulus: `w_ready` held 1; sources always valid with bytes 0x10..0x13 and 0x20..0x22; two `o_valid` pulses.
  - Required: `w_data` sequence 10,11,12,13; `i_data` sequence 20,21,22 on consecutive cycles; `done` for one cycle; `o_cnt`=2; `err`=0.
- Backpressure:
  - Stimulus: `w_ready` low for 3 cycles while `w_valid`=1.
  - Required: `w_data` stable; `ws_ready`=0; no byte lost or duplicated; exactly 4 core transfers.
- Input gaps:
  - Stimulus: `is_valid` pattern 1,0,0,1,1.
  - Required: `i_valid` pattern 1,0,0,1,1 one cycle later; WAIT_O entered after the third byte.
- Spurious result:
  - Stimulus: `o_valid` during LOAD_W.
  - Required: `err`=1 and `o_cnt` unchanged. `err` stays 1 through `done` and clears on the next `start`.
- Reset mid-operation:
  - Stimulus: `rst` in LOAD_I after 1 input byte.
  - Required: next cycle all outputs at reset values, no `done`. A new job then completes normally.
- Ignored start:
  - Stimulus: `start` pulses during LOAD_W and WAIT_O.
  - Required: no state or counter change; single `done`.
